// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller.
// Drives an external 64-bit adder one partial product per cycle.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [63:0]        add_a,
  output logic [63:0]        add_b,
  output logic               add_cin,
  output logic               add_sub,
  input  logic [63:0]        add_s
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [63:0]   p, m, p_nx, ext_a;
  logic [WIDTH-1:0] q;
  logic [CW-1:0] cnt;
  logic          sgn;
  logic          last;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign add_cin = 1'b0;

  // Multiplicand widened to adder width, signed or unsigned.
  always_comb begin
    ext_a = {{(64 - WIDTH){is_signed & op_a[WIDTH-1]}}, op_a};
  end

  // Partial product after this cycle's conditional add.
  always_comb begin
    p_nx = q[0] ? add_s : p;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and adder operand steering.
  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    add_sub  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CALC;
      end
      CALC: begin
        add_a   = p;
        add_b   = m;
        add_sub = last & sgn & q[0];
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration, result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      m       <= '0;
      q       <= '0;
      cnt     <= '0;
      sgn     <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            p   <= '0;
            m   <= ext_a;
            q   <= op_b;
            cnt <= '0;
            sgn <= is_signed;
          end
        end
        CALC: begin
          p   <= p_nx;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + CW'(1);
          if (last) product <= p_nx[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl at WIDTH=32.
// Includes a behavioural adder and a plain-arithmetic product model.
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          busy, done;
  logic [2*W-1:0] product;
  logic [63:0]   add_a, add_b, add_s;
  logic          add_cin, add_sub;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sub(add_sub), .add_s(add_s)
  );

  assign add_s = add_sub ? (add_a - add_b)
                         : (add_a + add_b + {63'd0, add_cin});

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] prod;
    int          dcyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  logic [63:0] last_prod = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint          sa, sb_;
    longint unsigned ua, ub;
    if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic logic [63:0] ext64(input logic [31:0] a,
                                        input logic s);
    return s ? {{32{a[31]}}, a} : {32'd0, a};
  endfunction

  // Monitor: adder port checks each cycle, result checks on done.
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      last_prod = '0;
    end else begin
      chk("add_cin", {63'd0, add_cin}, 64'd0);
      if (!busy) begin
        chk("idle_add_a", add_a, 64'd0);
        chk("idle_add_b", add_b, 64'd0);
        chk("idle_add_sub", {63'd0, add_sub}, 64'd0);
      end else if (sb.size() == 0) begin
        chk("busy_without_op", {63'd0, busy}, 64'd0);
      end else begin
        logic [63:0] e, mask, pe;
        logic        se;
        e    = ext64(sb[0].a, sb[0].s);
        mask = (busy_run == 0) ? 64'd0 : ((64'd1 << busy_run) - 64'd1);
        pe   = e * ({32'd0, sb[0].b} & mask);
        se   = (busy_run == W - 1) && sb[0].s && sb[0].b[W-1];
        chk("add_b", add_b, e << busy_run);
        chk("add_a", add_a, pe);
        chk("add_sub", {63'd0, add_sub}, {63'd0, se});
        busy_run++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("product", product, x.prod);
          chk("done_cycle", 64'(cyc), 64'(x.dcyc));
          chk("busy_len", 64'(busy_run), 64'(W));
          last_prod = x.prod;
        end
        busy_run = 0;
      end else begin
        chk("product_hold", product, last_prod);
      end
    end
  end

  // Issue one operation once the unit is idle; returns accept cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, output int acc);
    int w;
    w = 0;
    while ((busy || done) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("idle_wait", {62'd0, busy, done}, 64'd0);
    start     = 1'b1;
    op_a      = a;
    op_b      = b;
    is_signed = s;
    acc       = cyc;
    sb.push_back('{a, b, s, ref_mul(a, b, s), cyc + W + 1});
    @(posedge clk); #1;
    start     = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
    is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy || done) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c1, c2, w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_add_a", add_a, 64'd0);
    chk("rst_add_b", add_b, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd3, 32'd5, 1'b0, c1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, c2);
    chk("b2b_accept", 64'(c2), 64'(c1 + W + 2));
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, c1);
    run_op(32'h80000000, 32'h80000000, 1'b1, c1);
    run_op(32'd7, 32'hFFFFFFFF, 1'b1, c1);

    // start pulses mid-CALC and during DONE must be ignored
    run_op(32'h1234, 32'h5678, 1'b0, c1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op_a = 32'hDEAD; op_b = 32'hBEEF; is_signed = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!done && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    start = 1'b1; op_a = 32'h77; op_b = 32'h99;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("no_restart", {63'd0, busy}, 64'd0);

    // reset in CALC cycle 10 aborts the operation
    run_op(32'hABCD, 32'h1357, 1'b0, c1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_product", product, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd2, 32'd3, 1'b0, c1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = '0;
      if (i % 8 == 1) b = '0;
      run_op(a, b, 1'($urandom), c1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
